// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings and the fetch-stage
// types used by the instruction fetch unit and its memory.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_AND   = 8'h02;
    localparam logic [7:0] OP_OR    = 8'h03;
    localparam logic [7:0] OP_MOV   = 8'h08;
    localparam logic [7:0] OP_SUB   = 8'h09;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // One output-buffer slot: the instruction word and the byte PC it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_rom.sv
// Instruction memory: DEPTH x 32 array with one synchronous write port and one
// synchronous read port (1-cycle latency, read-before-write on address collision).
module instr_rom
    import cpu_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rdata_q;

    // NOTE: the array is deliberately left out of reset so it maps onto RAM; with
    // non-blocking writes a same-address read in the same cycle returns old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, RUN/HALT control, synchronous instruction memory
// and a 2-entry valid/ready output buffer with redirect-and-flush.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               run,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_addr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic               fault
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic [1:0]         count_q, count_d;
    fetch_entry_t       slot_q [2];
    fetch_entry_t       slot_d [2];

    logic               pop;
    logic               push;
    logic               pc_legal;
    logic [1:0]         occupancy;
    logic               attempt;
    logic               issue;
    logic [INSTR_W-1:0] rom_rdata;
    fetch_entry_t       new_entry;

    instr_rom #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rom (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .re_i    (issue),
        .raddr_i (pc_q[AW+1:2]),
        .rdata_o (rom_rdata)
    );

    assign pop       = (count_q != 2'd0) && instr_ready;
    assign push      = inflight_q;
    assign pc_legal  = (pc_q[1:0] == 2'b00) && (pc_q[PC_W-1:AW+2] == '0);
    // Occupancy the buffer will have once the in-flight word lands; never exceeds 2.
    assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign attempt   = (state_q == RUN) && run && !redirect && (occupancy < 2'd2);
    assign issue     = attempt && pc_legal;
    assign new_entry = '{instr: rom_rdata, pc: inflight_pc_q};

    // NOTE: every variable driven here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        slot_d[0]     = slot_q[0];
        slot_d[1]     = slot_q[1];

        if (redirect) begin
            state_d = RUN;
            pc_d    = redirect_addr;
            count_d = 2'd0;
        end else begin
            if (attempt && !pc_legal) begin
                state_d = HALT;
            end
            if (issue) begin
                pc_d          = pc_q + PC_STEP;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end

            // Shift-register buffer: slot 0 is always the head, and it keeps its
            // contents after the last pop so the outputs hold their final value.
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot_d[0] = new_entry;
                    end else begin
                        slot_d[1] = new_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        slot_d[0] = slot_q[1];
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        slot_d[0] = slot_q[1];
                        slot_d[1] = new_entry;
                    end else begin
                        slot_d[0] = new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            slot_q[0]     <= '0;
            slot_q[1]     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            slot_q[0]     <= slot_d[0];
            slot_q[1]     <= slot_d[1];
        end
    end

    assign instr_out   = slot_q[0].instr;
    assign pc_out      = slot_q[0].pc;
    assign instr_valid = (count_q != 2'd0);
    assign fault       = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the fetch rules.
module tb_instr_fetch;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        run;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic        fault;

    int vectors;
    int miscompares;

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    logic [31:0] pc_m;
    bit          halted_m;
    ent_t        buf_m [$];
    ent_t        pipe_m [$];
    ent_t        shown_m;

    instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .run           (run),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_out        (pc_out),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Applies the fetch rules to the model for the inputs present at this edge.
    task automatic model_edge();
        bit   pop;
        bit   attempt;
        bit   legal;
        int   occ;
        ent_t e;
        if (!reset) begin
            buf_m.delete();
            pipe_m.delete();
            pc_m     = 32'd0;
            halted_m = 1'b0;
            shown_m  = '0;
            if (prog_we) mem_m[prog_addr] = prog_data;
            return;
        end
        pop     = (buf_m.size() > 0) && instr_ready;
        occ     = buf_m.size() + pipe_m.size() - (pop ? 1 : 0);
        attempt = !halted_m && run && !redirect && (occ < 2);
        legal   = (pc_m % 4 == 0) && (pc_m < 32'(DEPTH * 4));
        if (pop) void'(buf_m.pop_front());
        if (redirect) begin
            buf_m.delete();
            pipe_m.delete();
            pc_m     = redirect_addr;
            halted_m = 1'b0;
        end else begin
            if (pipe_m.size() > 0) buf_m.push_back(pipe_m.pop_front());
            if (attempt) begin
                if (legal) begin
                    e.instr = mem_m[int'(pc_m / 4)];
                    e.pc    = pc_m;
                    pipe_m.push_back(e);
                    pc_m = pc_m + 32'd4;
                end else begin
                    halted_m = 1'b1;
                end
            end
        end
        if (prog_we) mem_m[prog_addr] = prog_data;
        if (buf_m.size() > 0) shown_m = buf_m[0];
    endtask

    task automatic compare();
        check("valid", 32'(instr_valid), 32'(buf_m.size() != 0));
        check("instr", instr_out, shown_m.instr);
        check("pc",    pc_out,    shown_m.pc);
        check("fault", 32'(fault), 32'(halted_m));
    endtask

    // Inputs are already driven; model the coming edge, then check after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(negedge clk);
            compare();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            2:       return 32'h3E0 + {$urandom_range(0, 7), 2'b00};
            default: return {22'd0, 8'($urandom), 2'b00};
        endcase
    endfunction

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        prog_we       = 1'b0;
        prog_addr     = '0;
        prog_data     = '0;
        run           = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        instr_ready   = 1'b0;
        step(2);

        // Program load under reset: test-plan words first, random fill after.
        prog_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            prog_addr = 8'(i);
            case (i)
                0:       prog_data = 32'h0004_00FF;
                1:       prog_data = 32'h0006_00AA;
                2:       prog_data = 32'h0003_00BB;
                3:       prog_data = 32'h0105_0603;
                default: prog_data = $urandom;
            endcase
            step();
        end
        prog_we = 1'b0;

        // Stream, then back-pressure for 5 cycles, then resume.
        reset = 1'b1; run = 1'b1; instr_ready = 1'b1;
        step(8);
        instr_ready = 1'b0;
        step(5);
        instr_ready = 1'b1;
        step(6);

        // Redirect to 8 while PCs 0 and 4 sit in the buffer.
        redirect = 1'b1; redirect_addr = 32'h0;
        step();
        redirect = 1'b0; instr_ready = 1'b0;
        step(4);
        redirect = 1'b1; redirect_addr = 32'h8;
        step();
        redirect = 1'b0; instr_ready = 1'b1;
        step(6);

        // Misaligned redirect halts; redirect to 0 recovers.
        redirect = 1'b1; redirect_addr = 32'h6;
        step();
        redirect = 1'b0;
        step(3);
        check("fault_misaligned", 32'(fault), 32'd1);
        redirect = 1'b1; redirect_addr = 32'h0;
        step();
        redirect = 1'b0;
        step(6);

        // Run off the end of memory.
        redirect = 1'b1; redirect_addr = 32'h3F0;
        step();
        redirect = 1'b0;
        step(10);
        check("fault_end_of_mem", 32'(fault), 32'd1);

        // Reset with two words buffered.
        redirect = 1'b1; redirect_addr = 32'h0;
        step();
        redirect = 1'b0; instr_ready = 1'b0;
        step(4);
        reset = 1'b0;
        step();
        check("valid_after_reset", 32'(instr_valid), 32'd0);
        reset = 1'b1; instr_ready = 1'b1;
        step(6);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 199) != 0);
            run           = ($urandom_range(0, 9) != 0);
            instr_ready   = ($urandom_range(0, 9) < 7);
            redirect      = ($urandom_range(0, 39) == 0);
            redirect_addr = rand_addr();
            prog_we       = ($urandom_range(0, 19) == 0);
            prog_addr     = 8'($urandom);
            prog_data     = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of `Processor`. It holds the program counter and a synchronous instruction memory, and presents one 32-bit instruction word per cycle on `instr_out`, which drives the processor's `Read_Addr` input. A 2-entry output buffer with a valid/ready handshake lets the downstream stage stall without dropping words. A redirect port reloads the PC and flushes all fetched work.

## Interface
- `DEPTH`, 256: instruction memory depth in 32-bit words (power of 2).
- `AW`, 8: word-address width, equal to log2(`DEPTH`).
- `clk`, in, 1: single clock; all state updates on posedge.
- `reset`, in, 1: synchronous, active-low reset, sampled on posedge `clk`.
- `prog_we`, in, 1: program-load write enable.
- `prog_addr`, in, `AW`: word index for the program load.
- `prog_data`, in, 32: instruction word to write.
- `run`, in, 1: fetch enable.
- `redirect`, in, 1: load the PC from `redirect_addr` and flush.
- `redirect_addr`, in, 32: new byte-address PC.
- `instr_out`, out, 32: instruction at buffer head; feeds `Read_Addr`.
- `instr_valid`, out, 1: buffer head holds a valid word.
- `instr_ready`, in, 1: downstream accepts the head word this cycle.
- `pc_out`, out, 32: byte address of `instr_out`.
- `fault`, out, 1: sticky flag, set when a fetch hits an illegal PC.

## Operation
- **PC:** 32-bit byte address, word index `pc[AW+1:2]`. Each issued fetch adds 4, with modulo 2^32 wrap.
- **Legal PC:** `pc[1:0]==0` and `pc[31:AW+2]==0`. Any other value is illegal.
- **FSM states:** `RUN`, `HALT`.
  - `RUN` to `HALT`: an issue is attempted with an illegal PC. No read occurs, `fault` is set, and the PC holds.
  - `HALT` to `RUN`: on `redirect` only. `fault` clears on the same edge.
- **Issue:** happens when `state==RUN`, `run==1`, `redirect==0`, PC is legal, and `count + inflight - pop < 2`.
  - `pop = instr_valid & instr_ready`.
  - `inflight` is 1 if an issue happened in the previous cycle and was not flushed.
- **Memory:** synchronous read with 1-cycle latency. `prog_we` writes on posedge.
  - A read and a write to the same address in the same cycle return the old data.
- **Buffer:** 2-entry FIFO holding {instruction, pc}. The head drives `instr_out` and `pc_out`.
  - A word returning from memory is pushed on the edge after its issue.
  - Push and pop in the same cycle are allowed.
  - Overflow cannot occur because of the issue rule.
- **Redirect:** on that edge:
  - PC is set to `redirect_addr`.
  - The buffer is emptied.
  - The in-flight read is discarded.
  - `state` becomes `RUN`.
  - A pop in the same cycle counts as a completed transfer.
  - Redirect beats issue and push.
- **`run` deasserted:** no new issue. An in-flight word still lands, and buffered words still drain.
- **`HALT`:** buffered words still drain. `instr_valid` falls once the buffer is empty.
- **When `instr_valid==0`:** `instr_out` and `pc_out` hold their last values (0 after reset).

## Timing
- **Reset (`reset==0` at posedge):**
  - PC=0, `state=RUN`, buffer empty, `inflight=0`.
  - `instr_valid=0`, `instr_out=0`, `pc_out=0`, `fault=0`.
  - Memory contents are not cleared.
- **Reset mid-operation:** all in-flight and buffered words are lost. No word issued before reset appears afterwards.
- **Latency:** an issue in cycle n gives `instr_valid` in cycle n+2, provided the buffer is empty.
- **Throughput:** 1 word per cycle sustained while `instr_ready==1`.
- **Stall:** with `instr_ready==0`, at most 2 words are buffered and issue stops. Resuming gives one word per cycle with no bubble and no duplicate.
- **Redirect in cycle n:**
  - `instr_valid=0` in cycle n+1.
  - First new word appears in cycle n+3: issue in n+1, push at the end of n+2.
- **Valid hold:** `instr_out` and `pc_out` are stable while `instr_valid==1 && instr_ready==0`.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W=32`, `PC_W=32`, `PC_STEP=4`.
  - Opcode constants: LOADI=8'h00, ADD=8'h01, AND=8'h02, OR=8'h03, MOV=8'h08, SUB=8'h09.
  - Fetch FSM state enum.
- One sub-module, `instr_rom`: the synchronous-read, synchronous-write `DEPTH`x32 array.
- The FIFO, PC and FSM live in `instr_fetch`.

## Test plan
- **Program and stream:** load words 0..3 = 32'h0004_00FF, 32'h0006_00AA, 32'h0003_00BB, 32'h0105_0603. Release reset with `run=1` and `instr_ready=1`. Expect `instr_valid` rising 2 cycles after the first issue, then those 4 words on consecutive cycles with `pc_out` = 0, 4, 8, 12.
- **Back-pressure:** hold `instr_ready=0` for 5 cycles mid-stream. Expect at most 2 buffered words, `instr_out` stable throughout, and the resumed sequence with no gap, loss or duplicate.
- **Redirect:** assert `redirect` with `redirect_addr=32'h8` while the buffer holds PCs 0 and 4. Expect `instr_valid=0` the next cycle, and the first new word to carry `pc_out=8` with instruction 32'h0003_00BB, 3 cycles after the redirect.
- **Fault:** set `redirect_addr=32'h6`. Expect `fault=1`, no issue, and state `HALT`. A subsequent redirect to 0 clears `fault` and restarts fetch from word 0.
- **End of memory:** with `DEPTH=256`, stream up to PC 32'h3FC. Expect the word at 32'h3FC delivered, then `fault=1` at PC 32'h400.
- **Reset mid-stream:** drive `reset=0` for 1 cycle with 2 words buffered. Expect all outputs at their reset values on the next cycle and fetch restarting at `pc_out=0`.
